score_bcd_keeper: RTL

- Upstream producer of the 3-digit BCD score consumed by the score-string renderers (in-game and end-screen).
- Counts point events from the game logic in packed BCD, saturates at a ceiling, and freezes on game over.
- Publishes a frame-stable copy for the text overlays, updated only on a frame tick so digits never change mid-frame.
- Optionally tracks the session best score.

---
 rtl/score_bcd_keeper_pkg.sv | 16 +
 rtl/score_bcd_keeper_bcd_inc3.sv | 33 +++
 rtl/score_bcd_keeper.sv | 123 ++++++++++++
 3 files changed

// File: rtl/score_bcd_keeper_pkg.sv
// Shared widths and state encoding for the BCD score keeper.
// Optional session-best tracking is enabled by defining SCORE_HISCORE_EN.
// `define SCORE_HISCORE_EN
package score_bcd_keeper_pkg;

    localparam int SCORE_DIGITS = 3;
    localparam int BCD_W        = 4;
    localparam int SCORE_W      = SCORE_DIGITS * BCD_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        FROZEN  = 2'd2
    } state_t;

endpackage

// File: rtl/score_bcd_keeper_bcd_inc3.sv
// Combinational packed-BCD adder: 3-digit value plus a single-digit step.
// The carry ripples through all digits; overflow flags a carry out of hundreds.
module bcd_inc3
    import score_bcd_keeper_pkg::*;
(
    input  logic [SCORE_W-1:0] value,
    input  logic [BCD_W-1:0]   step,
    output logic [SCORE_W-1:0] sum,
    output logic               overflow
);

    logic [SCORE_DIGITS:0] carry;

    assign carry[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < SCORE_DIGITS; gi++) begin : g_digit
            logic [BCD_W:0] raw;
            logic [BCD_W-1:0] addend;

            assign addend = (gi == 0) ? step : '0;
            assign raw    = {1'b0, value[gi*BCD_W +: BCD_W]} + {1'b0, addend}
                          + {{BCD_W{1'b0}}, carry[gi]};
            assign carry[gi+1] = (raw > 5'd9);
            // Low nibble minus ten wraps modulo 16 to the correct digit.
            assign sum[gi*BCD_W +: BCD_W] = carry[gi+1] ? (raw[BCD_W-1:0] - 4'd10)
                                                        : raw[BCD_W-1:0];
        end
    endgenerate

    assign overflow = carry[SCORE_DIGITS];

endmodule

// File: rtl/score_bcd_keeper.sv
// Game score counter in packed BCD with saturation, freeze on game over and a
// frame-stable display copy. SCORE_HISCORE_EN adds session-best tracking.
module score_bcd_keeper
    import score_bcd_keeper_pkg::*;
#(
    parameter int                   SCORE_STEP = 1,
    parameter logic [SCORE_W-1:0]   MAX_SCORE  = 12'h999
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               game_start,
    input  logic               game_over,
    input  logic               point,
    input  logic               frame_tick,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] score_live,
    output logic               running,
    output logic               saturated
`ifdef SCORE_HISCORE_EN
    ,
    output logic [SCORE_W-1:0] best_score,
    output logic               new_record
`endif
);

    localparam logic [BCD_W-1:0] STEP_NIB = BCD_W'(SCORE_STEP);

    state_t             state_reg, state_next;
    logic               point_q_reg;
    logic               evt;
    logic [SCORE_W-1:0] live_reg, live_next;
    logic [SCORE_W-1:0] score_reg, score_next;
    logic [SCORE_W-1:0] inc_sum;
    logic               inc_ovf;
    logic               saturated_reg, running_reg;
    logic               freeze_now, score_load;

    assign evt = point & ~point_q_reg;

    bcd_inc3 u_inc (
        .value    (live_reg),
        .step     (STEP_NIB),
        .sum      (inc_sum),
        .overflow (inc_ovf)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (game_start) state_next = RUNNING;
            RUNNING: begin
                if (game_start)     state_next = RUNNING;
                else if (game_over) state_next = FROZEN;
            end
            FROZEN:  if (game_start) state_next = RUNNING;
            default: state_next = IDLE;
        endcase
    end

    // game_start wins over everything; an event coinciding with game_over still counts.
    always_comb begin
        freeze_now = (state_reg == RUNNING) && game_over && !game_start;
        live_next  = live_reg;
        if (game_start) begin
            live_next = '0;
        end else if ((state_reg == RUNNING) && evt) begin
            live_next = (inc_ovf || (inc_sum > MAX_SCORE)) ? MAX_SCORE : inc_sum;
        end
        score_load = frame_tick | game_start | freeze_now;
        score_next = score_load ? live_next : score_reg;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            point_q_reg   <= 1'b0;
            live_reg      <= '0;
            score_reg     <= '0;
            saturated_reg <= 1'b0;
            running_reg   <= 1'b0;
        end else begin
            point_q_reg   <= point;
            live_reg      <= live_next;
            score_reg     <= score_next;
            saturated_reg <= (live_next == MAX_SCORE);
            running_reg   <= (state_next == RUNNING);
        end
    end

    assign score      = score_reg;
    assign score_live = live_reg;
    assign running    = running_reg;
    assign saturated  = saturated_reg;

`ifdef SCORE_HISCORE_EN
    logic [SCORE_W-1:0] best_reg;
    logic               new_record_reg;

    // Packed BCD compares correctly as plain binary.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            best_reg       <= '0;
            new_record_reg <= 1'b0;
        end else if (game_start) begin
            new_record_reg <= 1'b0;
        end else if (freeze_now && (live_next > best_reg)) begin
            best_reg       <= live_next;
            new_record_reg <= 1'b1;
        end
    end

    assign best_score = best_reg;
    assign new_record = new_record_reg;
`endif

endmodule
